// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller:
// FSM states, access size codes, IO region decode and owner encoding.
package mem_ctrl_pkg;

    localparam int ADDR    = 32;
    localparam int REGLINE = 32;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2
    } mc_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [ADDR-1:0] IO_MASK = 32'h0003_0000;
    localparam logic [ADDR-1:0] IO_CMP  = 32'h0003_0000;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Index of the final byte of an access; undefined size code 2'b11 acts as a word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR-1:0] addr);
        return (addr & IO_MASK) == IO_CMP;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter (bit 0 = fetch, bit 1 = load/store); combinational,
// on a tie the requester not granted last wins.
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == OWN_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller shared by fetch and load/store; N-byte read or write completes N+1 cycles after grant.
// rdy low freezes all state; with MEMCTRL_IO_STALL_EN, IO-region stores wait while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [7:0]         mem_din,
    output logic [7:0]         mem_dout,
    output logic [ADDR-1:0]    mem_a,
    output logic               mem_wr,
    input  logic               io_buffer_full,
    input  logic               flush,
    input  logic               if_req,
    input  logic [ADDR-1:0]    if_addr,
    output logic               if_done,
    output logic [REGLINE-1:0] if_data,
    input  logic               ls_req,
    input  logic               ls_wr,
    input  logic [1:0]         ls_size,
    input  logic [ADDR-1:0]    ls_addr,
    input  logic [REGLINE-1:0] ls_wdata,
    output logic               ls_done,
    output logic [REGLINE-1:0] ls_rdata
);

    mc_state_t          state_q, state_d;
    logic [1:0]         cnt_q, cnt_d, nlast_q, nlast_d;
    logic               owner_q, owner_d, last_q, last_d;
    logic [ADDR-1:0]    base_q, base_d, mem_a_q, mem_a_d;
    logic [REGLINE-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic [7:0]         mem_dout_q, mem_dout_d;
    logic               mem_wr_q, mem_wr_d;
    logic               if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic [REGLINE-1:0] if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;

    logic               if_elig, ls_elig;
    logic [1:0]         grant;
    logic [1:0]         cnt_nxt;
    logic [REGLINE-1:0] read_word;

    // A requester whose done is pulsing still holds its old request; mask it for that cycle.
    assign if_elig = if_req && !if_done_q;
`ifdef MEMCTRL_IO_STALL_EN
    assign ls_elig = ls_req && !ls_done_q && !(ls_wr && is_io(ls_addr) && io_buffer_full);
`else
    logic io_full_unused;
    assign io_full_unused = io_buffer_full;
    assign ls_elig = ls_req && !ls_done_q;
`endif

    mem_rr_arbiter u_arb (
        .req   ({ls_elig, if_elig}),
        .last  (last_q),
        .grant (grant)
    );

    assign cnt_nxt   = cnt_q + 2'd1;
    assign read_word = rbuf_q | ({24'd0, mem_din} << {cnt_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nlast_d    = nlast_q;
        owner_d    = owner_q;
        last_d     = last_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            MC_IDLE: begin
                if (!flush && (grant != 2'b00)) begin
                    owner_d = grant[1];
                    last_d  = grant[1];
                    cnt_d   = 2'd0;
                    rbuf_d  = '0;
                    wdata_d = ls_wdata;
                    base_d  = grant[1] ? ls_addr : if_addr;
                    mem_a_d = grant[1] ? ls_addr : if_addr;
                    nlast_d = grant[1] ? size_last(ls_size) : 2'd3;
                    if (grant[1] && ls_wr) begin
                        state_d    = MC_WRITE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = ls_wdata[7:0];
                    end else begin
                        state_d  = MC_READ;
                        mem_wr_d = 1'b0;
                    end
                end
            end
            MC_READ: begin
                if (flush) begin
                    state_d  = MC_IDLE;
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                end else begin
                    rbuf_d = read_word;
                    if (cnt_q == nlast_q) begin
                        state_d = MC_IDLE;
                        mem_a_d = '0;
                        if (owner_q == OWN_LS) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = read_word;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = read_word;
                        end
                    end else begin
                        cnt_d   = cnt_nxt;
                        mem_a_d = base_q + {30'd0, cnt_nxt};
                    end
                end
            end
            MC_WRITE: begin
                // Stores are already committed, so a flush here is deliberately ignored.
                if (cnt_q == nlast_q) begin
                    state_d   = MC_IDLE;
                    mem_wr_d  = 1'b0;
                    mem_a_d   = '0;
                    ls_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nxt;
                    mem_a_d    = base_q + {30'd0, cnt_nxt};
                    mem_dout_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MC_IDLE;
            cnt_q      <= 2'd0;
            nlast_q    <= 2'd0;
            owner_q    <= OWN_IF;
            last_q     <= OWN_IF;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nlast_q    <= nlast_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q && rdy;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of load/store vectors plus hand-written
// sequences for arbitration, flush, rdy stall and the IO store stall.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full, flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .flush          (flush),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    // RAM contents: the fetch word at 0x1000 is 13 05 00 00, everything else is addr[7:0]+0x11.
    // The byte on mem_din belongs to the address the controller registered at the previous edge.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1001: return 8'h05;
            32'h0000_1002: return 8'h00;
            32'h0000_1003: return 8'h00;
            default:       return a[7:0] + 8'h11;
        endcase
    endfunction

    assign mem_din = ram_byte(mem_a);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    localparam int MAXC = 24;
    logic [31:0] a_seen [MAXC];
    logic        w_seen [MAXC];
    logic [7:0]  d_seen [MAXC];
    int          if_dq[$];
    int          ls_dq[$];
    logic [31:0] if_data_s, ls_data_s;

    // One bounded transaction window. Inputs change right after each negedge sample,
    // so a value driven in cycle c is what the edge ending cycle c sees.
    task automatic run(input bit use_if, input bit use_ls, input bit hold,
                       input logic wr, input logic [1:0] size,
                       input logic [31:0] iaddr, input logic [31:0] laddr,
                       input logic [31:0] wdata, input int ncyc, input int flush_c,
                       input int full_n, input int rdy_lo, input int rdy_hi);
        if_dq.delete();
        ls_dq.delete();
        for (int c = 0; c < MAXC; c++) begin
            a_seen[c] = '0;
            w_seen[c] = 1'b0;
            d_seen[c] = '0;
        end
        if_req = use_if;  if_addr = iaddr;
        ls_req = use_ls;  ls_wr = wr;  ls_size = size;  ls_addr = laddr;  ls_wdata = wdata;
        flush = (flush_c == 0);
        io_buffer_full = (full_n > 0);
        rdy = !(rdy_lo <= 0 && rdy_hi >= 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            a_seen[c] = mem_a;
            w_seen[c] = mem_wr;
            d_seen[c] = mem_dout;
            if (if_done) begin
                if_dq.push_back(c);
                if_data_s = if_data;
                if (!hold) if_req = 1'b0;
            end
            if (ls_done) begin
                ls_dq.push_back(c);
                ls_data_s = ls_rdata;
                if (!hold) ls_req = 1'b0;
            end
            flush = (flush_c == c);
            io_buffer_full = (c < full_n);
            rdy = !(c >= rdy_lo && c <= rdy_hi);
        end
        if_req = 1'b0;  ls_req = 1'b0;  flush = 1'b0;  io_buffer_full = 1'b0;  rdy = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_done;
    } vec_t;

    vec_t tbl [8];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    initial begin
        tbl[0] = '{1'b0, 2'b00, 32'h0000_0003, 32'h0,         32'h0000_0014, 2};
        tbl[1] = '{1'b0, 2'b01, 32'h0000_20FF, 32'h0,         32'h0000_1110, 3};
        tbl[2] = '{1'b0, 2'b10, 32'h0000_2040, 32'h0,         32'h5453_5251, 5};
        tbl[3] = '{1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0,         32'h1312_1110, 5};
        tbl[4] = '{1'b0, 2'b10, 32'h0000_1000, 32'h0,         32'h0000_0513, 5};
        tbl[5] = '{1'b1, 2'b01, 32'h0000_2002, 32'hABCD_1234, 32'h0,         3};
        tbl[6] = '{1'b1, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,         5};
        tbl[7] = '{1'b1, 2'b00, 32'h0003_0000, 32'h0000_00C3, 32'h0,         2};

        rst = 1'b1;  rdy = 1'b1;  io_buffer_full = 1'b0;  flush = 1'b0;
        if_req = 1'b0;  if_addr = '0;
        ls_req = 1'b0;  ls_wr = 1'b0;  ls_size = 2'b00;  ls_addr = '0;  ls_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset mem_a",    mem_a,    32'h0);
        check("reset mem_wr",   mem_wr,   32'h0);
        check("reset mem_dout", mem_dout, 32'h0);
        check("reset if_done",  if_done,  32'h0);
        check("reset ls_done",  ls_done,  32'h0);
        check("reset if_data",  if_data,  32'h0);
        check("reset ls_rdata", ls_rdata, 32'h0);

        for (int i = 0; i < 8; i++) begin
            int n;
            logic [31:0] sh;
            n = nbytes(tbl[i].sz);
            run(1'b0, 1'b1, 1'b0, tbl[i].wr, tbl[i].sz, 32'h0, tbl[i].addr, tbl[i].wdata,
                tbl[i].exp_done + 3, -1, 0, 0, -1);
            check($sformatf("v%0d done cycle", i), (ls_dq.size() > 0) ? ls_dq[0] : -1, tbl[i].exp_done);
            check($sformatf("v%0d done pulses", i), ls_dq.size(), 1);
            check($sformatf("v%0d stray if_done", i), if_dq.size(), 0);
            if (!tbl[i].wr) check($sformatf("v%0d rdata", i), ls_data_s, tbl[i].exp_rd);
            for (int k = 0; k < n; k++) begin
                check($sformatf("v%0d addr byte%0d", i, k), a_seen[k+1], tbl[i].addr + k);
                check($sformatf("v%0d mem_wr byte%0d", i, k), w_seen[k+1], tbl[i].wr);
                if (tbl[i].wr) begin
                    sh = tbl[i].wdata >> (8 * k);
                    check($sformatf("v%0d dout byte%0d", i, k), d_seen[k+1], sh[7:0]);
                end
            end
            check($sformatf("v%0d mem_a idle", i), a_seen[tbl[i].exp_done], 32'h0);
            check($sformatf("v%0d mem_wr idle", i), w_seen[tbl[i].exp_done], 32'h0);
        end

        // Instruction fetch of the word at 0x1000.
        run(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 8, -1, 0, 0, -1);
        check("fetch done cycle", (if_dq.size() > 0) ? if_dq[0] : -1, 5);
        check("fetch data", if_data_s, 32'h0000_0513);
        check("fetch addr byte0", a_seen[1], 32'h1000);
        check("fetch addr byte3", a_seen[4], 32'h1003);
        check("fetch mem_wr", w_seen[1] | w_seen[2] | w_seen[3] | w_seen[4] | w_seen[5], 32'h0);

        // Simultaneous requests: LS wins the first tie, then grants alternate.
        run(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h1000, 32'h2040, 32'h0, 15, -1, 0, 0, -1);
        check("tie ls first done", (ls_dq.size() > 0) ? ls_dq[0] : -1, 5);
        check("tie if done", (if_dq.size() > 0) ? if_dq[0] : -1, 10);
        check("tie ls second done", (ls_dq.size() > 1) ? ls_dq[1] : -1, 15);
        check("tie ls data", ls_data_s, 32'h5453_5251);
        check("tie if data", if_data_s, 32'h0000_0513);

        // Flush in the second cycle of a fetch; the still-held request restarts at byte 0.
        run(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 10, 2, 0, 0, -1);
        check("flush fetch done cycle", (if_dq.size() > 0) ? if_dq[0] : -1, 8);
        check("flush fetch pulses", if_dq.size(), 1);
        check("flush idle mem_a", a_seen[3], 32'h0);
        check("flush restart addr", a_seen[4], 32'h1000);
        check("flush fetch data", if_data_s, 32'h0000_0513);

        // Flush in IDLE blocks that cycle's grant.
        run(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h3, 32'h0, 6, 0, 0, 0, -1);
        check("idle flush done cycle", (ls_dq.size() > 0) ? ls_dq[0] : -1, 3);
        check("idle flush data", ls_data_s, 32'h0000_0014);

        // Flush during a word store does not abort it.
        run(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 32'h5000, 32'h0102_0304, 8, 2, 0, 0, -1);
        check("flush store done cycle", (ls_dq.size() > 0) ? ls_dq[0] : -1, 5);
        check("flush store wr byte3", w_seen[4], 32'h1);
        check("flush store addr byte3", a_seen[4], 32'h5003);
        check("flush store dout byte3", d_seen[4], 32'h01);

        // rdy low for two edges mid-fetch.
        run(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, 32'h0, 10, -1, 0, 2, 3);
        check("rdy frozen addr c3", a_seen[3], 32'h1001);
        check("rdy frozen addr c4", a_seen[4], 32'h1001);
        check("rdy fetch done cycle", (if_dq.size() > 0) ? if_dq[0] : -1, 7);
        check("rdy fetch data", if_data_s, 32'h0000_0513);

        // rdy low during a half store: mem_wr masked, byte reissued.
        run(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h6000, 32'h0000_5A66, 7, -1, 0, 1, 1);
        check("rdy store masked wr", w_seen[2], 32'h0);
        check("rdy store frozen addr", a_seen[2], 32'h6000);
        check("rdy store wr byte1", w_seen[3], 32'h1);
        check("rdy store dout byte1", d_seen[3], 32'h5A);
        check("rdy store done cycle", (ls_dq.size() > 0) ? ls_dq[0] : -1, 4);

        // IO-region byte store while the IO buffer reports full for six edges.
        run(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0003_0000, 32'h0000_00C3, 11, -1, 6, 0, -1);
`ifdef MEMCTRL_IO_STALL_EN
        check("io stall no write c6", w_seen[6], 32'h0);
        check("io stall wr c7", w_seen[7], 32'h1);
        check("io stall addr c7", a_seen[7], 32'h0003_0000);
        check("io stall done cycle", (ls_dq.size() > 0) ? ls_dq[0] : -1, 8);
`else
        check("io ignored wr c1", w_seen[1], 32'h1);
        check("io ignored addr c1", a_seen[1], 32'h0003_0000);
        check("io ignored done cycle", (ls_dq.size() > 0) ? ls_dq[0] : -1, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller that shares the byte-wide RAM/IO bus between the instruction-fetch path (ICache miss) and the load/store buffer. It serialises each 1/2/4-byte transaction into byte accesses, assembles read data little-endian, arbitrates round-robin between the two requesters, and honours rollback flushes and the IO back-pressure signal. It sits between ICache/LSB and the top-level `mem_din/mem_dout/mem_a/mem_wr` pins.

## Interface
- No parameters; widths come from `define.v` (`ADDR` = 32 bits, data 32 bits).
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; low freezes all state.
- `mem_din` in 8: RAM/IO read byte for the address presented in the previous cycle.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: IO write FIFO full.
- `flush` in 1: misprediction rollback.
- `if_req` in 1, `if_addr` in 32: fetch request (4 bytes), held until `if_done`.
- `if_done` out 1, `if_data` out 32: one-cycle completion pulse and word.
- `ls_req` in 1, `ls_wr` in 1, `ls_size` in 2 (00 byte, 01 half, 10 word), `ls_addr` in 32, `ls_wdata` in 32: LSB request, held stable until `ls_done`.
- `ls_done` out 1, `ls_rdata` out 32: completion pulse; load data zero-extended (LSB does sign extension).

## Operation
- States: IDLE, READ, WRITE. Byte counter `cnt` 0..3; length N = 1/2/4 (fetch always 4).
- IDLE: if exactly one eligible request, grant it. If both eligible, grant the requester not granted last; `last` resets to IF, so LS wins the first tie.
- Grant edge: latch owner, base, N, wdata; drive `mem_a` = base; `cnt` = 0. Load/fetch -> READ with `mem_wr` = 0. Store -> WRITE with `mem_wr` = 1, `mem_dout` = wdata[7:0].
- READ: each cycle, the byte on `mem_din` goes to data[8k+7:8k] for byte k = `cnt`; `mem_a` = base + `cnt` + 1 while bytes remain. After byte N-1 is captured, pulse the owner's done with the data; upper bytes are 0. Then go to IDLE with `mem_a` = 0.
- WRITE: byte k is driven with `mem_a` = base + k for one cycle. After byte N-1, `mem_wr` = 0, owner's done pulses, then IDLE.
- Address add is 32-bit, modulo 2^32. A read at 0xFFFFFFFF wraps to 0x00000000.
- IO region: `addr[17:16]` = 2'b11.
- flush while READ (IF or LS owner): abort at that edge. Go to IDLE, no done pulse, `mem_a` = 0, `mem_wr` = 0. Requests sampled in the flush cycle are ignored.
- flush while WRITE: ignored. Committed stores always complete, and done still pulses.
- flush in IDLE: no grant that cycle.
- `rdy` = 0: no register updates. `mem_wr` is forced to 0 combinationally. The pending byte is reissued when `rdy` returns.

## Timing
- Reset values: `mem_a` 0, `mem_dout` 0, `mem_wr` 0, `if_done` 0, `ls_done` 0, `if_data` 0, `ls_rdata` 0, state IDLE, `cnt` 0, `last` = IF.
- Read of N bytes: done is high in cycle N+1 after the grant edge (word fetch: 5 cycles).
- Write of N bytes: `mem_wr` is high for cycles 1..N, done in cycle N+1.
- Done is high exactly one cycle, then IDLE for one cycle. The earliest next grant is the edge after done, so there is no back-to-back transfer without a 1-cycle gap.
- Data outputs hold their value until the next completion of the same port.

## Configuration
- `MEMCTRL_IO_STALL_EN` defined: an LS store to the IO region is ineligible while `io_buffer_full` = 1. It is held and not granted. IF may be granted meanwhile.
- Not defined: `io_buffer_full` is ignored (simulation-only builds).

## Structure
- In `define.v`:
  - state encodings `MC_IDLE/MC_READ/MC_WRITE`
  - size codes `SIZE_B/SIZE_H/SIZE_W`
  - IO region mask/compare constants
  - `ADDR` and `REGLINE` widths
- Optional sub-module `mem_rr_arbiter`: 2-requester round-robin. Inputs: `req[1:0]`, `last`. Outputs: one-hot `grant`. All sequencing stays in `mem_ctrl`.

## Test plan
- Fetch at 0x1000 with RAM bytes 13,05,00,00:
  - `mem_a` steps 0x1000..0x1003.
  - `if_done` is high at cycle 5 with `if_data` = 0x00000513.
  - `mem_wr` stays 0.
- Half store 0xABCD1234 at 0x2002: `mem_wr` is high 2 cycles with (0x2002,0x34) then (0x2003,0x12); `ls_done` at cycle 3.
- `if_req` and `ls_req` raised together on the first grant after reset: LS is served first. IF is granted on the edge after `ls_done`. With both still requesting, grants alternate.
- `flush` on cycle 2 of a fetch:
  - no `if_done`
  - IDLE next cycle
  - the following fetch restarts at byte 0
- `flush` during a word store: all 4 bytes are written and `ls_done` pulses.
- Byte store to 0x30000 with `MEMCTRL_IO_STALL_EN` and `io_buffer_full` = 1 for 6 cycles: no write issued. It is granted the edge after full drops. `rdy` low mid-read: `mem_a` is frozen and data is still correct.
